// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage and imem.
// One request strobe per fetch, response returns after a latency.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns fetch PC, one outstanding imem request,
// a one-entry instruction buffer and the IF/ID hold/flush controls.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              exc,
    if_fetch_if.master        imem,
    output logic [31:0]       out_address,
    output logic [31:0]       out_instruction,
    output logic              out_valid,
    output logic              hold_ifid,
    output logic              flush_ifid
);

    localparam logic [1:0] ISSUE = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FULL  = 2'd3;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] ibuf;
    logic [31:0] ibuf_pc;
    logic        kill;
    logic [31:0] target;
    logic        xfer;

    assign kill   = exc | redirect;
    assign target = exc ? EXC_VECTOR : (redirect_pc & 32'hFFFF_FFFC);
    assign xfer   = (state == FULL) & !stall & !kill;

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    always_comb begin
        imem.imem_req = 1'b0;
        if (rst_n) begin
            case (state)
                ISSUE:   imem.imem_req = !kill;
                FULL:    imem.imem_req = xfer;
                default: imem.imem_req = 1'b0;
            endcase
        end
    end

    assign imem.imem_addr  = fetch_pc;
    assign out_address     = ibuf_pc;
    assign out_instruction = ibuf;
    assign out_valid       = (state == FULL);
    assign hold_ifid       = !(rst_n & xfer);
    assign flush_ifid      = rst_n & kill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ISSUE;
            fetch_pc <= RESET_PC;
            ibuf     <= 32'h0;
            ibuf_pc  <= 32'h0;
        end else begin
            case (state)
                ISSUE: begin
                    if (kill) fetch_pc <= target;
                    else      state    <= WAIT;
                end
                WAIT: begin
                    if (kill) begin
                        fetch_pc <= target;
                        state    <= imem.imem_rvalid ? ISSUE : DRAIN;
                    end else if (imem.imem_rvalid) begin
                        ibuf     <= imem.imem_rdata;
                        ibuf_pc  <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= FULL;
                    end
                end
                DRAIN: begin
                    if (kill)             fetch_pc <= target;
                    if (imem.imem_rvalid) state    <= ISSUE;
                end
                FULL: begin
                    if (kill) begin
                        fetch_pc <= target;
                        state    <= ISSUE;
                    end else if (!stall) begin
                        state <= WAIT;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule
